// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters, one byte per grant.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       spi_start,
    output logic [DATA_W-1:0]          spi_tx_data,
    input  logic                       spi_done,
    input  logic [DATA_W-1:0]          spi_rx_data,
    output logic [NUM_REQ-1:0]         ss_n
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, GAP} state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     last_reg, last_next;
    logic [GAP_W-1:0]    gap_reg, gap_next;
    logic [NUM_REQ-1:0]  ss_n_reg, ss_n_next;
    logic [NUM_REQ-1:0]  ack_reg, ack_next;
    logic                err_reg, err_next;
    logic                busy_reg, busy_next;
    logic [ID_W-1:0]     grant_reg, grant_next;
    logic                start_reg, start_next;
    logic [DATA_W-1:0]   tx_reg, tx_next;
    logic [DATA_W-1:0]   rsp_reg, rsp_next;

    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     rr_idx;
    logic                found;
    logic                expire;
    logic [DATA_W-1:0]   req_word [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan downward so the requester closest after last_reg is the final (winning) assignment.
    always_comb begin
        pick   = last_reg;
        found  = 1'b0;
        rr_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = ID_W'((int'(last_reg) + k) % NUM_REQ);
            if (req[rr_idx]) begin
                pick  = rr_idx;
                found = 1'b1;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] timer_reg;

    always_ff @(posedge clk) begin
        if (rst || state_reg != WAIT) timer_reg <= '0;
        else                          timer_reg <= timer_reg + 1'b1;
    end

    assign expire = (state_reg == WAIT) && (timer_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (found) state_next = SETUP;
            SETUP:   state_next = WAIT;
            WAIT:    if (spi_done || expire) state_next = GAP;
            GAP:     if (gap_reg <= GAP_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_next  = last_reg;
        gap_next   = gap_reg;
        ss_n_next  = ss_n_reg;
        ack_next   = '0;
        err_next   = 1'b0;
        busy_next  = (state_next != IDLE);
        grant_next = grant_reg;
        start_next = 1'b0;
        tx_next    = tx_reg;
        rsp_next   = rsp_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_next = pick;
                    last_next  = pick;
                    tx_next    = req_word[pick];
                    ss_n_next  = ~(NUM_REQ'(1) << pick);
                end
            end
            SETUP: start_next = 1'b1;
            WAIT: begin
                // A completion coinciding with watchdog expiry is treated as a normal completion.
                if (spi_done || expire) begin
                    ack_next  = NUM_REQ'(1) << grant_reg;
                    ss_n_next = '1;
                    gap_next  = GAP_W'(GAP_CYCLES);
                    rsp_next  = spi_done ? spi_rx_data : '0;
                    err_next  = !spi_done;
                end
            end
            GAP: gap_next = gap_reg - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            last_reg  <= ID_W'(NUM_REQ - 1);
            gap_reg   <= '0;
            ss_n_reg  <= '1;
            ack_reg   <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            grant_reg <= '0;
            start_reg <= 1'b0;
            tx_reg    <= '0;
            rsp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            gap_reg   <= gap_next;
            ss_n_reg  <= ss_n_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
            grant_reg <= grant_next;
            start_reg <= start_next;
            tx_reg    <= tx_next;
            rsp_reg   <= rsp_next;
        end
    end

    assign ss_n        = ss_n_reg;
    assign ack         = ack_reg;
    assign err         = err_reg;
    assign busy        = busy_reg;
    assign grant_id    = grant_reg;
    assign spi_start   = start_reg;
    assign spi_tx_data = tx_reg;
    assign rsp_data    = rsp_reg;
endmodule
